// File: rtl/pu_dispatch.sv
// Command dispatcher for a bank of slave PUs: enable/launch/ack control,
// per-PU watchdog, completion tracking and a lowest-index interrupt encoder.
module pu_dispatch #(
  parameter int unsigned N_PU = 7,
  parameter int unsigned DW   = 8,
  parameter int unsigned TO_W = 8,
  parameter int unsigned IDW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_op,
  input  logic [IDW-1:0]  cmd_id,
  output logic            cmd_ready,
  input  logic [DW-1:0]   ctx_sa,
  input  logic [DW-1:0]   ctx_sb,
  input  logic [DW-1:0]   ctx_sc,
  input  logic [DW-1:0]   ctx_ip,
  output logic [DW-1:0]   pu_sa,
  output logic [DW-1:0]   pu_sb,
  output logic [DW-1:0]   pu_sc,
  output logic [DW-1:0]   pu_ip,
  output logic [N_PU-1:0] en_pu,
  output logic [N_PU-1:0] start_pu,
  input  logic [N_PU-1:0] done_pu,
  output logic [N_PU-1:0] stat_busy,
  output logic [N_PU-1:0] stat_done,
  output logic [N_PU-1:0] stat_to,
  output logic            irq,
  output logic [IDW-1:0]  irq_id,
  output logic            cmd_err
);

  typedef enum logic {IDLE, LAUNCH} state_t;

  localparam logic [1:0] OP_EN    = 2'd0;
  localparam logic [1:0] OP_DIS   = 2'd1;
  localparam logic [1:0] OP_START = 2'd2;
  localparam logic [1:0] OP_ACK   = 2'd3;
  // Watchdog value one below saturation: the next busy cycle times out.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state, state_nxt;
  logic            accept, bad, go;
  logic [N_PU-1:0] hit;
  logic [N_PU-1:0] pend;
  logic [TO_W-1:0] wd [N_PU];

  // Command decode and next-state logic
  always_comb begin
    state_nxt = state;
    cmd_ready = (state == IDLE);
    accept    = cmd_valid && (state == IDLE);
    hit       = N_PU'(1) << cmd_id;
    bad       = 1'b0;
    if (32'(cmd_id) >= N_PU) begin
      bad = 1'b1;
    end else if (cmd_op == OP_START &&
                 (!(|(en_pu & hit)) || (|(stat_busy & hit)))) begin
      bad = 1'b1;
    end
    go = accept && !bad && (cmd_op == OP_START);
    case (state)
      IDLE:    if (go) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      en_pu     <= '0;
      start_pu  <= '0;
      stat_busy <= '0;
      stat_done <= '0;
      stat_to   <= '0;
      cmd_err   <= 1'b0;
      pu_sa     <= '0;
      pu_sb     <= '0;
      pu_sc     <= '0;
      pu_ip     <= '0;
      for (int i = 0; i < N_PU; i++) wd[i] <= '0;
    end else begin
      state    <= state_nxt;
      cmd_err  <= accept && bad;
      start_pu <= go ? hit : '0;
      if (go) begin
        pu_sa <= ctx_sa;
        pu_sb <= ctx_sb;
        pu_sc <= ctx_sc;
        pu_ip <= ctx_ip;
      end
      for (int i = 0; i < N_PU; i++) begin
        // Completion beats a coincident timeout; events beat a coincident ACK.
        if (stat_busy[i]) begin
          if (done_pu[i]) begin
            stat_busy[i] <= 1'b0;
            stat_done[i] <= 1'b1;
          end else begin
            wd[i] <= wd[i] + TO_W'(1);
            if (wd[i] == WD_LAST) begin
              stat_busy[i] <= 1'b0;
              stat_to[i]   <= 1'b1;
            end
          end
        end
        if (accept && !bad && hit[i]) begin
          case (cmd_op)
            OP_EN:  en_pu[i] <= 1'b1;
            OP_DIS: begin
              en_pu[i]     <= 1'b0;
              stat_busy[i] <= 1'b0;
              wd[i]        <= '0;
            end
            OP_START: begin
              stat_busy[i] <= 1'b1;
              stat_done[i] <= 1'b0;
              stat_to[i]   <= 1'b0;
              wd[i]        <= '0;
            end
            default: begin
              if (!(stat_busy[i] && done_pu[i])) stat_done[i] <= 1'b0;
              if (!(stat_busy[i] && !done_pu[i] && wd[i] == WD_LAST)) stat_to[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Interrupt: pending bits of enabled PUs, lowest index reported
  always_comb begin
    pend   = (stat_done | stat_to) & en_pu;
    irq    = |pend;
    irq_id = '0;
    for (int i = int'(N_PU) - 1; i >= 0; i--) begin
      if (pend[i]) irq_id = IDW'(i);
    end
  end

endmodule

// File: tb/tb_pu_dispatch.sv
// Scoreboard bench for pu_dispatch: directed commands push expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pu_dispatch;

  localparam int N = 7;
  localparam int DW = 8;
  localparam int TOW = 4;
  localparam int IDW = 4;
  localparam logic [1:0] OP_EN = 2'd0, OP_DIS = 2'd1, OP_START = 2'd2, OP_ACK = 2'd3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic [1:0]     cmd_op = '0;
  logic [IDW-1:0] cmd_id = '0;
  logic           cmd_ready;
  logic [DW-1:0]  ctx_sa = '0, ctx_sb = '0, ctx_sc = '0, ctx_ip = '0;
  logic [DW-1:0]  pu_sa, pu_sb, pu_sc, pu_ip;
  logic [N-1:0]   en_pu, start_pu, stat_busy, stat_done, stat_to;
  logic [N-1:0]   done_pu = '0;
  logic           irq, cmd_err;
  logic [IDW-1:0] irq_id;

  pu_dispatch #(.N_PU(N), .DW(DW), .TO_W(TOW), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_id(cmd_id), .cmd_ready(cmd_ready),
    .ctx_sa(ctx_sa), .ctx_sb(ctx_sb), .ctx_sc(ctx_sc), .ctx_ip(ctx_ip),
    .pu_sa(pu_sa), .pu_sb(pu_sb), .pu_sc(pu_sc), .pu_ip(pu_ip),
    .en_pu(en_pu), .start_pu(start_pu), .done_pu(done_pu),
    .stat_busy(stat_busy), .stat_done(stat_done), .stat_to(stat_to),
    .irq(irq), .irq_id(irq_id), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {S_EN, S_BUSY, S_DONE, S_TO, S_IRQ, S_IRQID, S_READY, S_START, S_PUIP, S_ERR} sel_e;
  typedef struct {int cyc; sel_e sel; logic [31:0] val;} chk_t;
  typedef struct {logic [N-1:0] mask; logic [DW-1:0] ip;} st_t;

  chk_t q_chk[$];
  st_t  q_start[$];
  int   q_err[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] sample(sel_e s);
    case (s)
      S_EN:    return 32'(en_pu);
      S_BUSY:  return 32'(stat_busy);
      S_DONE:  return 32'(stat_done);
      S_TO:    return 32'(stat_to);
      S_IRQ:   return 32'(irq);
      S_IRQID: return 32'(irq_id);
      S_READY: return 32'(cmd_ready);
      S_START: return 32'(start_pu);
      S_PUIP:  return 32'(pu_ip);
      default: return 32'(cmd_err);
    endcase
  endfunction

  task automatic chk(input int dly, input sel_e s, input logic [31:0] v);
    chk_t c;
    c.cyc = cyc + dly;
    c.sel = s;
    c.val = v;
    q_chk.push_back(c);
  endtask

  task automatic exp_start(input logic [N-1:0] m, input logic [DW-1:0] ip);
    st_t e;
    e.mask = m;
    e.ip   = ip;
    q_start.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns in the first cycle in which the command's effects are visible.
  task automatic issue(input logic [1:0] op, input int id);
    int w = 0;
    while (!cmd_ready && w < 20) begin
      step();
      w++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_id    = IDW'(id);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    done_pu = m;
    step();
    done_pu = '0;
  endtask

  // Monitor: start pulses and error pulses pop their queues; timed checks fire on their cycle.
  always @(negedge clk) begin
    if (start_pu != '0) begin
      n_vec++;
      if (q_start.size() == 0) begin
        n_bad++;
        $display("FAIL start_pulse: unexpected start_pu=%b at cyc %0d", start_pu, cyc);
      end else begin
        st_t e;
        e = q_start.pop_front();
        if (start_pu !== e.mask || pu_ip !== e.ip || cmd_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL start_pulse: got start=%b ip=%h ready=%b required start=%b ip=%h ready=0",
                   start_pu, pu_ip, cmd_ready, e.mask, e.ip);
        end
      end
    end
    if (cmd_err === 1'b1) begin
      n_vec++;
      if (q_err.size() == 0) begin
        n_bad++;
        $display("FAIL cmd_err: unexpected pulse at cyc %0d", cyc);
      end else begin
        void'(q_err.pop_front());
      end
    end
    for (int i = 0; i < q_chk.size(); ) begin
      if (q_chk[i].cyc == cyc) begin
        logic [31:0] act;
        act = sample(q_chk[i].sel);
        n_vec++;
        if (act !== q_chk[i].val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got 0x%0h required 0x%0h",
                   q_chk[i].sel.name(), cyc, act, q_chk[i].val);
        end
        q_chk.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    // Reset state
    step(3);
    reset = 1'b0;
    chk(0, S_EN, 0); chk(0, S_BUSY, 0); chk(0, S_DONE, 0); chk(0, S_TO, 0);
    chk(0, S_READY, 1); chk(0, S_IRQ, 0); chk(0, S_PUIP, 0); chk(0, S_START, 0);
    step();

    // Enable and launch PU2
    issue(OP_EN, 2);
    chk(0, S_EN, 'h04);
    ctx_ip = 8'h3C; ctx_sa = 8'h11;
    exp_start(7'h04, 8'h3C);
    issue(OP_START, 2);
    chk(0, S_BUSY, 'h04); chk(0, S_READY, 0); chk(0, S_PUIP, 'h3C);
    chk(1, S_START, 0); chk(1, S_READY, 1);
    pulse(7'h04);
    chk(0, S_DONE, 'h04); chk(0, S_BUSY, 0); chk(0, S_IRQ, 1); chk(0, S_IRQID, 2);
    issue(OP_ACK, 2);
    chk(0, S_DONE, 0); chk(0, S_IRQ, 0); chk(0, S_IRQID, 0);

    // Rejected starts: disabled PU, then out-of-range id
    ctx_ip = 8'hAA;
    q_err.push_back(4);
    issue(OP_START, 4);
    chk(0, S_ERR, 1); chk(0, S_BUSY, 0); chk(0, S_START, 0); chk(0, S_READY, 1);
    q_err.push_back(9);
    issue(OP_START, 9);
    chk(0, S_ERR, 1); chk(0, S_DONE, 0); chk(0, S_TO, 0); chk(0, S_EN, 'h04);
    chk(0, S_PUIP, 'h3C); chk(1, S_ERR, 0);
    step();

    // Watchdog timeout on PU1 after 15 busy cycles
    issue(OP_EN, 1);
    chk(0, S_EN, 'h06);
    ctx_ip = 8'h51;
    exp_start(7'h02, 8'h51);
    issue(OP_START, 1);
    chk(0, S_PUIP, 'h51);
    chk(14, S_BUSY, 'h02); chk(14, S_TO, 0); chk(14, S_IRQ, 0);
    chk(15, S_TO, 'h02); chk(15, S_BUSY, 0); chk(15, S_IRQ, 1); chk(15, S_IRQID, 1);
    step(15);
    issue(OP_ACK, 1);
    chk(0, S_TO, 0); chk(0, S_IRQ, 0);

    // Simultaneous completion of PU3 and PU5, masking by disable
    issue(OP_EN, 3);
    issue(OP_EN, 5);
    chk(0, S_EN, 'h2E);
    ctx_ip = 8'h33;
    exp_start(7'h08, 8'h33);
    issue(OP_START, 3);
    ctx_ip = 8'h55;
    exp_start(7'h20, 8'h55);
    issue(OP_START, 5);
    chk(0, S_BUSY, 'h28); chk(0, S_PUIP, 'h55);
    pulse(7'h28);
    chk(0, S_DONE, 'h28); chk(0, S_BUSY, 0); chk(0, S_IRQ, 1); chk(0, S_IRQID, 3);
    issue(OP_ACK, 3);
    chk(0, S_IRQID, 5); chk(0, S_DONE, 'h20);
    issue(OP_DIS, 5);
    chk(0, S_IRQ, 0); chk(0, S_IRQID, 0); chk(0, S_DONE, 'h20); chk(0, S_EN, 'h0E);
    issue(OP_EN, 5);
    chk(0, S_IRQ, 1); chk(0, S_IRQID, 5);
    issue(OP_ACK, 5);
    chk(0, S_IRQ, 0);

    // ACK coincident with DONE on PU6, then DONE coincident with timeout
    issue(OP_EN, 6);
    ctx_ip = 8'h66;
    exp_start(7'h40, 8'h66);
    issue(OP_START, 6);
    step();
    cmd_valid = 1'b1; cmd_op = OP_ACK; cmd_id = 4'd6; done_pu = 7'h40;
    step();
    cmd_valid = 1'b0; done_pu = '0;
    chk(0, S_DONE, 'h40); chk(0, S_BUSY, 0); chk(0, S_IRQID, 6);
    issue(OP_ACK, 6);
    chk(0, S_DONE, 0);
    exp_start(7'h40, 8'h66);
    issue(OP_START, 6);
    chk(14, S_BUSY, 'h40);
    step(14);
    pulse(7'h40);
    chk(0, S_DONE, 'h40); chk(0, S_TO, 0); chk(0, S_BUSY, 0);
    issue(OP_ACK, 6);
    chk(0, S_IRQ, 0);

    // Reset during the launch cycle aborts the start pulse
    issue(OP_EN, 0);
    ctx_ip = 8'h77;
    exp_start(7'h01, 8'h77);
    cmd_valid = 1'b1; cmd_op = OP_START; cmd_id = '0;
    step();
    cmd_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk(0, S_START, 0); chk(0, S_EN, 0); chk(0, S_READY, 1); chk(0, S_BUSY, 0);
    chk(0, S_PUIP, 0); chk(0, S_IRQ, 0); chk(0, S_ERR, 0); chk(0, S_DONE, 0);
    step(3);

    // Anything still queued was never observed
    foreach (q_start[i]) begin
      n_vec++; n_bad++;
      $display("FAIL start_pulse: missing start=%b ip=%h", q_start[i].mask, q_start[i].ip);
    end
    foreach (q_err[i]) begin
      n_vec++; n_bad++;
      $display("FAIL cmd_err: missing pulse for id %0d", q_err[i]);
    end
    foreach (q_chk[i]) begin
      n_vec++; n_bad++;
      $display("FAIL %s: check for cyc %0d never evaluated", q_chk[i].sel.name(), q_chk[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pu_dispatch.md
PU_DISPATCH -- requirements
Module: pu_dispatch

Interface
REQ-001 Parameter N_PU, default 7: number of slave PUs (1..16).
REQ-002 Parameter DW, default 8: context word width (SA/SB/SC/IP).
REQ-003 Parameter TO_W, default 8: width of the per-PU watchdog counter.
REQ-004 Parameter IDW, default 4: command PU-index width; N_PU <= 2^IDW.
REQ-005 CLK  in  1  the single clock; all logic on rising edge.
REQ-006 RESET  in  1  reset, synchronous and active-high.
REQ-007 CMD_VALID  in  1  command strobe.
REQ-008 CMD_OP  in  2  00=ENABLE, 01=DISABLE, 10=START, 11=ACK.
REQ-009 CMD_ID  in  IDW  target PU index, 0..N_PU-1.
REQ-010 CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY.
REQ-011 CTX_SA, CTX_SB, CTX_SC, CTX_IP  in  DW each  launch context sampled at START accept.
REQ-012 PU_SA, PU_SB, PU_SC, PU_IP  out  DW each  registered launch context broadcast to slaves.
REQ-013 EN_PU  out  N_PU  per-PU enable.
REQ-014 START_PU  out  N_PU  one-hot start pulse.
REQ-015 DONE_PU  in  N_PU  per-PU completion, level or pulse; each cycle high counts as an event.
REQ-016 STAT_BUSY, STAT_DONE, STAT_TO  out  N_PU each  running / completed-unacked / timed-out flags.
REQ-017 IRQ  out  1  OR of (STAT_DONE | STAT_TO) over enabled PUs.
REQ-018 IRQ_ID  out  IDW  lowest index with a pending DONE or TO bit; 0 when IRQ low.
REQ-019 CMD_ERR  out  1  one-cycle pulse on rejected command.

Function
REQ-020 FSM states IDLE, LAUNCH; CMD_READY = 1 only in IDLE.
REQ-021 IDLE: accepted START with no error -> LAUNCH; all other accepts stay IDLE; LAUNCH -> IDLE unconditionally after one cycle.
REQ-022 START accept: latch CTX_* into PU_*; in LAUNCH drive START_PU[id]=1 for exactly one cycle; STAT_BUSY[id] set, STAT_DONE[id] and STAT_TO[id] cleared, watchdog[id] loaded to 0, all on the same edge as LAUNCH entry.
REQ-023 PU_* hold their value until the next accepted error-free START.
REQ-024 ENABLE sets EN_PU[id]; DISABLE clears EN_PU[id], STAT_BUSY[id], watchdog[id]; both complete the cycle after accept.
REQ-025 ACK clears STAT_DONE[id] and STAT_TO[id].
REQ-026 Rejected, with CMD_ERR pulsed the cycle after accept and no state change: CMD_ID >= N_PU; START to a PU with EN_PU=0; START to a PU with STAT_BUSY=1.
REQ-027 DONE_PU[i] while STAT_BUSY[i]: clear STAT_BUSY[i], set STAT_DONE[i]; DONE_PU[i] while not busy is ignored.
REQ-028 Watchdog[i] increments each cycle while STAT_BUSY[i]; reaching 2^TO_W-1 clears STAT_BUSY[i] and sets STAT_TO[i]; the counter never wraps.
REQ-029 Same cycle DONE_PU[i] and timeout: DONE wins (STAT_DONE set, STAT_TO unchanged).
REQ-030 Same cycle ACK[i] and DONE_PU[i]: STAT_DONE[i] ends set (new event wins).
REQ-031 Simultaneous DONE on several PUs: all recorded in one cycle; IRQ_ID = lowest index.
REQ-032 IRQ, IRQ_ID are combinational from registered STAT_* and EN_PU; a disabled PU's pending bits stay stored but are masked.

Reset
REQ-033 RESET high at a rising edge: FSM=IDLE; EN_PU, START_PU, STAT_*, watchdogs, PU_*, CMD_ERR = 0; CMD_READY=1 the following cycle.
REQ-034 RESET during LAUNCH aborts the START pulse; the START_PU bit is 0 the cycle after reset.

Verification
REQ-035 Reset, ENABLE id2, START id2 with CTX_IP=0x3C -> START_PU=0b0000100 for one cycle, PU_IP=0x3C, STAT_BUSY[2]=1, CMD_READY=0 in that cycle.
REQ-036 START id4 while EN_PU[4]=0, then START id9 -> CMD_ERR pulses twice, no START_PU activity, no STAT_* change.
REQ-037 TO_W=4, PU1 running with no DONE -> STAT_TO[1]=1 and IRQ=1, IRQ_ID=1 after 15 busy cycles; ACK id1 -> IRQ=0.
REQ-038 PU3 and PU5 busy, DONE_PU=0b0101000 in one cycle -> STAT_DONE[3]=STAT_DONE[5]=1, IRQ_ID=3; ACK id3 -> IRQ_ID=5.
REQ-039 ACK id6 in the same cycle as DONE_PU[6] -> STAT_DONE[6]=1; DONE and timeout in the same cycle -> STAT_DONE=1, STAT_TO=0.
REQ-040 RESET asserted in the LAUNCH cycle -> all outputs 0 next cycle, CMD_READY=1, no residual START_PU pulse.
